// File: rtl/tm_program_loader.sv
// Replays a ROM program image into the Turing machine's input_data/Next/Done button
// interface, then steps the machine (free-run or single-step) until compute_done.
module tm_program_loader #(
    parameter int AW        = 6,
    parameter int W         = 64,
    parameter int RA        = 8,
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 4,
    parameter int FILL_CYC  = 70
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          run,
    input  logic          step,
    output logic [RA-1:0] rom_addr,
    input  logic [AW-1:0] rom_data,
    input  logic          compute_done,
    output logic [AW-1:0] input_data,
    output logic          Next,
    output logic          Done,
    output logic          busy,
    output logic          loaded,
    output logic          error,
    output logic [3:0]    dbg_state,
    output logic [2:0]    dbg_phase
);

    // Handshake: none. Every Next/Done pulse is PULSE_CYC high then GAP_CYC low, and
    // input_data changes only in LATCH, at least one SETUP cycle before Next rises.
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_FETCH    = 4'd1;
    localparam logic [3:0] ST_LATCH    = 4'd2;
    localparam logic [3:0] ST_SETUP    = 4'd3;
    localparam logic [3:0] ST_HIGH     = 4'd4;
    localparam logic [3:0] ST_LOW      = 4'd5;
    localparam logic [3:0] ST_FILL     = 4'd6;
    localparam logic [3:0] ST_RUN_WAIT = 4'd7;
    localparam logic [3:0] ST_STEP_HI  = 4'd8;
    localparam logic [3:0] ST_STEP_LO  = 4'd9;
    localparam logic [3:0] ST_HALTED   = 4'd10;
    localparam logic [3:0] ST_ERROR    = 4'd11;

    // Phase records which image field the shared fetch/pulse states are working on.
    localparam logic [2:0] PH_S     = 3'd0;
    localparam logic [2:0] PH_T     = 3'd1;
    localparam logic [2:0] PH_TABLE = 3'd2;
    localparam logic [2:0] PH_DONE1 = 3'd3;
    localparam logic [2:0] PH_A     = 3'd4;
    localparam logic [2:0] PH_M     = 3'd5;
    localparam logic [2:0] PH_TAPE  = 3'd6;
    localparam logic [2:0] PH_DONE2 = 3'd7;

    localparam int CMAX = (FILL_CYC > PULSE_CYC + GAP_CYC) ? FILL_CYC : PULSE_CYC + GAP_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    logic [3:0]    state_q, state_d;
    logic [2:0]    phase_q, phase_d;
    logic [RA-1:0] ptr_q, ptr_d;
    logic          wrap_q, wrap_d;
    logic [AW-1:0] data_q, data_d;
    logic [AW-1:0] count_q, count_d;
    logic [AW-1:0] word_q, word_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          loaded_q, loaded_d;
    logic          step_prev_q, step_prev_d;

    logic          step_edge;
    logic          is_done_phase;
    logic [AW-1:0] word_inc;

    assign step_edge     = step && !step_prev_q;
    assign is_done_phase = (phase_q == PH_DONE1) || (phase_q == PH_DONE2);
    assign word_inc      = word_q + AW'(1);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        ptr_d       = ptr_q;
        wrap_d      = wrap_q;
        data_d      = data_q;
        count_d     = count_q;
        word_d      = word_q;
        cyc_d       = cyc_q;
        loaded_d    = loaded_q;
        step_prev_d = step;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    phase_d = PH_S;
                    ptr_d   = '0;
                    wrap_d  = 1'b0;
                end
            end

            ST_FETCH: begin
                // A pointer that already wrapped would re-read the image start.
                if (wrap_q) begin
                    state_d = ST_ERROR;
                end else begin
                    ptr_d   = ptr_q + RA'(1);
                    wrap_d  = (ptr_q == '1);
                    state_d = ST_LATCH;
                end
            end

            ST_LATCH: begin
                case (phase_q)
                    PH_S: begin
                        if (rom_data == '0) begin
                            state_d = ST_ERROR;
                        end else begin
                            data_d  = rom_data;
                            state_d = ST_SETUP;
                        end
                    end
                    PH_T, PH_M: begin
                        count_d = rom_data;
                        word_d  = '0;
                        if (rom_data == '0) begin
                            phase_d = (phase_q == PH_T) ? PH_DONE1 : PH_DONE2;
                            state_d = ST_HIGH;
                            cyc_d   = '0;
                        end else begin
                            phase_d = (phase_q == PH_T) ? PH_TABLE : PH_TAPE;
                            state_d = ST_FETCH;
                        end
                    end
                    PH_A: begin
                        if (int'(rom_data) > W - 2) begin
                            state_d = ST_ERROR;
                        end else begin
                            data_d  = rom_data;
                            state_d = ST_SETUP;
                        end
                    end
                    default: begin
                        data_d  = rom_data;
                        state_d = ST_SETUP;
                    end
                endcase
            end

            ST_SETUP: begin
                state_d = ST_HIGH;
                cyc_d   = '0;
            end

            ST_HIGH: begin
                if (cyc_q == CW'(PULSE_CYC - 1)) begin
                    state_d = ST_LOW;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end

            ST_LOW: begin
                if (cyc_q == CW'(GAP_CYC - 1)) begin
                    cyc_d = '0;
                    case (phase_q)
                        PH_S: begin
                            phase_d = PH_T;
                            state_d = ST_FETCH;
                        end
                        PH_TABLE, PH_TAPE: begin
                            word_d = word_inc;
                            if (word_inc == count_q) begin
                                phase_d = (phase_q == PH_TABLE) ? PH_DONE1 : PH_DONE2;
                                state_d = ST_HIGH;
                            end else begin
                                state_d = ST_FETCH;
                            end
                        end
                        PH_DONE1: begin
                            phase_d = PH_A;
                            state_d = ST_FETCH;
                        end
                        PH_A, PH_DONE2: begin
                            state_d = ST_FILL;
                        end
                        default: begin
                            state_d = ST_ERROR;
                        end
                    endcase
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end

            ST_FILL: begin
                // Gives the machine time to sweep its memory before the next field.
                if (cyc_q == CW'(FILL_CYC - 1)) begin
                    cyc_d = '0;
                    if (phase_q == PH_A) begin
                        phase_d = PH_M;
                        state_d = ST_FETCH;
                    end else begin
                        loaded_d = 1'b1;
                        state_d  = ST_RUN_WAIT;
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end

            ST_RUN_WAIT: begin
                if (compute_done) begin
                    state_d = ST_HALTED;
                end else if (run || step_edge) begin
                    state_d = ST_STEP_HI;
                    cyc_d   = '0;
                end
            end

            ST_STEP_HI: begin
                if (cyc_q == CW'(PULSE_CYC - 1)) begin
                    state_d = ST_STEP_LO;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end

            ST_STEP_LO: begin
                // Step edges seen here are dropped; only RUN_WAIT consumes them.
                if (cyc_q == CW'(GAP_CYC - 1)) begin
                    state_d = ST_RUN_WAIT;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end

            ST_HALTED: state_d = ST_HALTED;
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_ERROR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_S;
            ptr_q       <= '0;
            wrap_q      <= 1'b0;
            data_q      <= '0;
            count_q     <= '0;
            word_q      <= '0;
            cyc_q       <= '0;
            loaded_q    <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            ptr_q       <= ptr_d;
            wrap_q      <= wrap_d;
            data_q      <= data_d;
            count_q     <= count_d;
            word_q      <= word_d;
            cyc_q       <= cyc_d;
            loaded_q    <= loaded_d;
            step_prev_q <= step_prev_d;
        end
    end

    // Buttons are gated by reset so a pulse in flight drops immediately.
    assign Next       = !reset && (((state_q == ST_HIGH) && !is_done_phase) || (state_q == ST_STEP_HI));
    assign Done       = !reset && (state_q == ST_HIGH) && is_done_phase;
    assign busy       = !((state_q == ST_IDLE) || (state_q == ST_HALTED) || (state_q == ST_ERROR));
    assign loaded     = loaded_q;
    assign error      = (state_q == ST_ERROR);
    assign rom_addr   = ptr_q;
    assign input_data = data_q;
    assign dbg_state  = state_q;
    assign dbg_phase  = phase_q;

endmodule

// File: tb/tb_tm_program_loader.sv
// Bench for tm_program_loader: a registered ROM model, a pulse monitor feeding a
// scoreboard of expected input_data values, and one task per scenario.
module tb_tm_program_loader;

    localparam int AW = 6;
    localparam int RA = 8;
    localparam int W  = 64;
    localparam int P  = 4;
    localparam int G  = 4;
    localparam int F  = 70;

    logic          clock = 1'b0;
    logic          reset, start, run, step, compute_done;
    logic [RA-1:0] rom_addr;
    logic [AW-1:0] rom_data;
    logic [AW-1:0] input_data;
    logic          next_o, done_o, busy, loaded, error;
    logic [3:0]    dbg_state;
    logic [2:0]    dbg_phase;

    logic [AW-1:0] rom [0:(1<<RA)-1];

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] exp_q[$];

    int load_pulses = 0, step_pulses = 0, done_pulses = 0, overlap_cnt = 0;
    int hi_len = 0;
    logic next_prev = 1'b0, done_prev = 1'b0;
    logic [AW-1:0] data_prev = '0, hold_val = '0;

    tm_program_loader #(
        .AW(AW), .W(W), .RA(RA), .PULSE_CYC(P), .GAP_CYC(G), .FILL_CYC(F)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .run(run), .step(step),
        .rom_addr(rom_addr), .rom_data(rom_data), .compute_done(compute_done),
        .input_data(input_data), .Next(next_o), .Done(done_o), .busy(busy),
        .loaded(loaded), .error(error), .dbg_state(dbg_state), .dbg_phase(dbg_phase)
    );

    // clock / reset / ROM
    always #5 clock = ~clock;
    always @(posedge clock) rom_data <= rom[rom_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulse monitor and scoreboard pop
    always @(negedge clock) begin
        if (reset) begin
            next_prev = 1'b0;
            done_prev = 1'b0;
            hi_len    = 0;
            data_prev = input_data;
        end else begin
            if (next_o && done_o) overlap_cnt++;
            if (next_o && !next_prev) begin
                hi_len   = 1;
                hold_val = input_data;
                if (!loaded) begin
                    load_pulses++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL load_pulse: unexpected Next pulse, data %0d, scoreboard empty", input_data);
                    end else begin
                        logic [AW-1:0] exp_v;
                        exp_v = exp_q.pop_front();
                        if (input_data !== exp_v) begin
                            errors++;
                            $display("FAIL load_data: got %0d expected %0d", input_data, exp_v);
                        end
                    end
                    checks++;
                    if (input_data !== data_prev) begin
                        errors++;
                        $display("FAIL data_setup: data %0d at Next rise, %0d one cycle earlier", input_data, data_prev);
                    end
                end else begin
                    step_pulses++;
                end
            end else if (next_o && next_prev) begin
                hi_len++;
                checks++;
                if (input_data !== hold_val) begin
                    errors++;
                    $display("FAIL data_hold: data %0d while Next high, expected %0d", input_data, hold_val);
                end
            end else if (!next_o && next_prev) begin
                checks++;
                if (hi_len != P) begin
                    errors++;
                    $display("FAIL next_width: high %0d cycles, expected %0d", hi_len, P);
                end
            end
            if (done_o && !done_prev) done_pulses++;
            next_prev = next_o;
            done_prev = done_o;
            data_prev = input_data;
        end
    end

    // driver tasks
    task automatic apply_reset();
        reset = 1'b1;
        start = 1'b0;
        run = 1'b0;
        step = 1'b0;
        compute_done = 1'b0;
        repeat (3) @(negedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < (1 << RA); i++) rom[i] = '0;
        exp_q.delete();
    endtask

    task automatic put(input int a, input int v, input bit pulsed);
        rom[a] = AW'(v);
        if (pulsed) exp_q.push_back(AW'(v));
    endtask

    task automatic do_start();
        @(negedge clock);
        #1 start = 1'b1;
        @(negedge clock);
        #1 start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            #1;
            if (loaded || error) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic image_t1();
        clear_rom();
        put(0, 2, 1);
        put(1, 3, 0);
        put(2, 5, 1);
        put(3, 9, 1);
        put(4, 1, 1);
        put(5, 20, 1);
        put(6, 2, 0);
        put(7, 1, 1);
        put(8, 0, 1);
    endtask

    // scenarios
    task automatic test_reset();
        clear_rom();
        apply_reset();
        @(negedge clock);
        #1;
        checks++; if (next_o !== 1'b0) begin errors++; $display("FAIL reset_next: got %b expected 0", next_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL reset_loaded: got %b expected 0", loaded); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
        checks++; if (rom_addr !== '0) begin errors++; $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
        checks++; if (input_data !== '0) begin errors++; $display("FAIL reset_input_data: got %0d expected 0", input_data); end
    endtask

    task automatic test_load();
        bit ok;
        int lp0, dp0;
        image_t1();
        lp0 = load_pulses;
        dp0 = done_pulses;
        repeat ($urandom_range(1, 5)) @(negedge clock);
        do_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy_start: got %b expected 1", busy); end
        wait_end(2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL load_timeout: loaded %b error %b after budget", loaded, error); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL load_scoreboard: %0d values left, expected 0", exp_q.size()); end
        checks++; if (load_pulses - lp0 != 7) begin errors++; $display("FAIL load_count: %0d Next pulses, expected 7", load_pulses - lp0); end
        checks++; if (done_pulses - dp0 != 2) begin errors++; $display("FAIL load_done_count: %0d Done pulses, expected 2", done_pulses - dp0); end
        checks++; if (loaded !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL load_flags: loaded %b error %b, expected 1 0", loaded, error); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy: got %b expected 1", busy); end
        checks++; if (rom_addr !== RA'(9)) begin errors++; $display("FAIL load_rom_addr: got %0d expected 9", rom_addr); end
    endtask

    task automatic test_free_run();
        int sp0, i;
        bit ok;
        sp0 = step_pulses;
        repeat (10) @(negedge clock);
        #1;
        checks++; if (step_pulses != sp0) begin errors++; $display("FAIL idle_steps: %0d steps with run=0, expected 0", step_pulses - sp0); end
        run = 1'b1;
        ok = 1'b0;
        for (i = 0; i < 300; i++) begin
            @(negedge clock);
            #1;
            if (step_pulses - sp0 == 5) begin ok = 1'b1; break; end
        end
        compute_done = 1'b1;
        checks++; if (!ok) begin errors++; $display("FAIL run_timeout: %0d steps, expected 5", step_pulses - sp0); end
        ok = 1'b0;
        for (i = 0; i < 60; i++) begin
            @(negedge clock);
            #1;
            if (!busy) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL run_busy_timeout: busy %b, expected 0", busy); end
        repeat (20) @(negedge clock);
        #1;
        checks++; if (step_pulses - sp0 != 5) begin errors++; $display("FAIL run_steps: %0d steps, expected 5", step_pulses - sp0); end
        checks++; if (busy !== 1'b0 || loaded !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL run_halt_flags: busy %b loaded %b error %b, expected 0 1 0", busy, loaded, error); end
        run = 1'b0;
        compute_done = 1'b0;
    endtask

    task automatic test_s_zero();
        int lp0, cyc;
        apply_reset();
        clear_rom();
        lp0 = load_pulses;
        @(negedge clock);
        #1 start = 1'b1;
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            #1 start = 1'b0;
            cyc++;
            if (error) break;
        end
        checks++; if (error !== 1'b1 || cyc > 3) begin errors++; $display("FAIL s_zero_error: error %b after %0d cycles, expected 1 within 3", error, cyc); end
        repeat (10) @(negedge clock);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL s_zero_busy: got %b expected 0", busy); end
        checks++; if (load_pulses != lp0) begin errors++; $display("FAIL s_zero_pulses: %0d Next pulses, expected 0", load_pulses - lp0); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL s_zero_sticky: got %b expected 1", error); end
    endtask

    task automatic test_a_bad();
        bit ok;
        int lp0, dp0;
        apply_reset();
        clear_rom();
        put(0, 1, 1);
        put(1, 1, 0);
        put(2, 7, 1);
        put(3, 63, 0);
        put(4, 1, 0);
        put(5, 3, 0);
        lp0 = load_pulses;
        dp0 = done_pulses;
        do_start();
        wait_end(1000, ok);
        repeat (100) @(negedge clock);
        #1;
        checks++; if (!ok || error !== 1'b1) begin errors++; $display("FAIL a_bad_error: error %b, expected 1", error); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL a_bad_scoreboard: %0d values left, expected 0", exp_q.size()); end
        checks++; if (load_pulses - lp0 != 2) begin errors++; $display("FAIL a_bad_pulses: %0d Next pulses, expected 2", load_pulses - lp0); end
        checks++; if (done_pulses - dp0 != 1) begin errors++; $display("FAIL a_bad_done: %0d Done pulses, expected 1", done_pulses - dp0); end
        checks++; if (busy !== 1'b0 || loaded !== 1'b0) begin errors++; $display("FAIL a_bad_flags: busy %b loaded %b, expected 0 0", busy, loaded); end
    endtask

    task automatic test_single_step();
        bit ok;
        int dp0, sp0, i;
        apply_reset();
        clear_rom();
        put(0, 1, 1);
        put(1, 0, 0);
        put(2, 0, 1);
        put(3, 0, 0);
        dp0 = done_pulses;
        do_start();
        wait_end(1000, ok);
        checks++; if (!ok || loaded !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL ss_load: loaded %b error %b, expected 1 0", loaded, error); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ss_scoreboard: %0d values left, expected 0", exp_q.size()); end
        checks++; if (done_pulses - dp0 != 2) begin errors++; $display("FAIL ss_done: %0d Done pulses, expected 2", done_pulses - dp0); end
        checks++; if (rom_addr !== RA'(4)) begin errors++; $display("FAIL ss_rom_addr: got %0d expected 4", rom_addr); end
        sp0 = step_pulses;
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clock);
            #1 step = 1'b0;
            repeat ($urandom_range(14, 24)) @(negedge clock);
            #1;
        end
        checks++; if (step_pulses - sp0 != 3) begin errors++; $display("FAIL ss_three_steps: %0d steps, expected 3", step_pulses - sp0); end
        sp0 = step_pulses;
        step = 1'b1;
        ok = 1'b0;
        for (i = 0; i < 20; i++) begin
            @(negedge clock);
            #1;
            if (step_pulses != sp0) begin ok = 1'b1; break; end
        end
        step = 1'b0;
        @(negedge clock);
        #1 step = 1'b1;
        @(negedge clock);
        #1 step = 1'b0;
        repeat (25) @(negedge clock);
        #1;
        checks++; if (!ok || step_pulses - sp0 != 1) begin errors++; $display("FAIL ss_edge_in_step: %0d steps, expected 1", step_pulses - sp0); end
        compute_done = 1'b1;
        repeat (5) @(negedge clock);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ss_halt_busy: got %b expected 0", busy); end
        compute_done = 1'b0;
    endtask

    task automatic test_reset_mid_pulse();
        bit ok;
        int lp0, i;
        apply_reset();
        image_t1();
        lp0 = load_pulses;
        do_start();
        ok = 1'b0;
        for (i = 0; i < 400; i++) begin
            @(negedge clock);
            #1;
            if (load_pulses - lp0 == 2) begin ok = 1'b1; break; end
        end
        checks++; if (!ok || next_o !== 1'b1) begin errors++; $display("FAIL mid_setup: Next %b, expected 1 in table pulse", next_o); end
        reset = 1'b1;
        @(negedge clock);
        #1;
        checks++; if (next_o !== 1'b0) begin errors++; $display("FAIL mid_next_drop: got %b expected 0", next_o); end
        checks++; if (busy !== 1'b0 || rom_addr !== '0) begin errors++; $display("FAIL mid_idle: busy %b rom_addr %0d, expected 0 0", busy, rom_addr); end
        @(negedge clock);
        #1 reset = 1'b0;
        image_t1();
        lp0 = load_pulses;
        do_start();
        wait_end(2000, ok);
        checks++; if (!ok || loaded !== 1'b1) begin errors++; $display("FAIL mid_reload: loaded %b, expected 1", loaded); end
        checks++; if (exp_q.size() != 0 || load_pulses - lp0 != 7) begin errors++; $display("FAIL mid_reload_pulses: %0d pulses, %0d left, expected 7 0", load_pulses - lp0, exp_q.size()); end
        checks++; if (rom_addr !== RA'(9)) begin errors++; $display("FAIL mid_rom_addr: got %0d expected 9", rom_addr); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_free_run();
        test_s_zero();
        test_a_bad();
        test_single_step();
        test_reset_mid_pulse();
        checks++;
        if (overlap_cnt != 0) begin
            errors++;
            $display("FAIL next_done_overlap: %0d cycles with both high, expected 0", overlap_cnt);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
